// File: rtl/grayscale_pack_fifo.sv
// Packs a stream of grayscale pixel bytes into 32-bit words and queues them in a small FIFO
// drained through a single-cycle CPU custom instruction (pop / status / clear).
module grayscale_pack_fifo #(
    parameter logic [7:0]  customInstructionId = 8'd14,
    parameter int unsigned fifoDepthLog2       = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pixelValid,
    input  logic [7:0]  pixelGray,
    input  logic        start,
    input  logic [7:0]  iseId,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);

    localparam int unsigned DEPTH = 1 << fifoDepthLog2;
    localparam logic [fifoDepthLog2:0] CNT_ONE  = 1;
    localparam logic [fifoDepthLog2:0] CNT_FULL = DEPTH[fifoDepthLog2:0];

    typedef enum logic [1:0] {
        OP_POP    = 2'd0,
        OP_STATUS = 2'd1,
        OP_CLEAR  = 2'd2,
        OP_RSVD   = 2'd3
    } op_t;

    logic [31:0]              mem [DEPTH];
    logic [fifoDepthLog2-1:0] wr_ptr, rd_ptr;
    logic [fifoDepthLog2:0]   count;
    logic [1:0]               byte_cnt;
    logic [23:0]              pack_reg;
    logic                     overflow;

    op_t         op;
    logic        accept, is_empty, is_full, word_done;
    logic        do_pop, do_clear, do_push;
    logic [31:0] status_word;
    logic        unused_bits;

    assign unused_bits = ^{valueB, valueA[31:2]};

    always_comb begin
        op          = op_t'(valueA[1:0]);
        accept      = start && (iseId == customInstructionId);
        is_empty    = (count == '0);
        is_full     = (count == CNT_FULL);
        word_done   = pixelValid && (byte_cnt == 2'd3);
        do_pop      = accept && (op == OP_POP) && !is_empty;
        do_clear    = accept && (op == OP_CLEAR);
        // A pop on the same edge frees the slot a completing word needs.
        do_push     = word_done && !do_clear && (!is_full || do_pop);
        status_word = '0;
        status_word[31] = overflow;
        status_word[30] = is_empty;
        status_word[29] = is_full;
        status_word[9:8] = byte_cnt;
        status_word[fifoDepthLog2:0] = count;
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= {pack_reg, pixelGray};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            byte_cnt <= '0;
            pack_reg <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            done   <= accept;
            result <= '0;
            if (accept) begin
                case (op)
                    OP_POP:    result <= is_empty ? '0 : mem[rd_ptr];
                    OP_STATUS: result <= status_word;
                    default:   result <= '0;
                endcase
            end

            if (do_clear) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                byte_cnt <= '0;
                overflow <= 1'b0;
            end else begin
                if (pixelValid) begin
                    byte_cnt <= byte_cnt + 2'd1;
                    case (byte_cnt)
                        2'd0:    pack_reg[23:16] <= pixelGray;
                        2'd1:    pack_reg[15:8]  <= pixelGray;
                        2'd2:    pack_reg[7:0]   <= pixelGray;
                        default: ;
                    endcase
                end
                if (word_done && !do_push) begin
                    overflow <= 1'b1;
                end
                if (do_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_grayscale_pack_fifo.sv
// Directed bench for grayscale_pack_fifo: the driver queues expected results, a negedge monitor
// checks every done pulse (value and one-cycle latency) and that result is 0 otherwise.
module tb_grayscale_pack_fifo;

    logic        clock = 1'b0;
    logic        reset;
    logic        pixelValid;
    logic [7:0]  pixelGray;
    logic        start;
    logic [7:0]  iseId;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc     = 0;
    int          n_check = 0;
    int          n_fail  = 0;

    grayscale_pack_fifo #(
        .customInstructionId(8'd14),
        .fifoDepthLog2(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .pixelValid(pixelValid),
        .pixelGray(pixelGray),
        .start(start),
        .iseId(iseId),
        .valueA(valueA),
        .valueB(valueB),
        .done(done),
        .result(result)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_check++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%08h required=%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: scoreboard pop on each done pulse, idle-result check otherwise.
    always @(negedge clock) begin
        exp_t e;
        if (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            check("done_missing", 32'd0, 32'd1);
        end
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                check("done_unexpected", {31'd0, done}, 32'd0);
            end else begin
                e = q.pop_front();
                check("done_latency", cyc, e.cyc);
                check("result", result, e.data);
            end
        end else begin
            check("done_known", {31'd0, done}, 32'd0);
            check("result_idle", result, 32'd0);
        end
    end

    task automatic drive(input logic pv, input logic [7:0] pg, input logic st,
                         input logic [7:0] id, input logic [1:0] op, input logic [31:0] exp_res);
        @(negedge clock);
        pixelValid = pv;
        pixelGray  = pg;
        start      = st;
        iseId      = id;
        valueA     = {30'h3FFF_FFFF, op} & {30'h0, 2'b11} | (st ? 32'hFFFF_FFFC : 32'h0);
        valueB     = 32'hDEAD_0000;
        if (st && id == 8'd14) q.push_back('{exp_res, cyc + 1});
    endtask

    task automatic pixel(input logic [7:0] b);
        drive(1'b1, b, 1'b0, 8'd0, 2'd0, 32'd0);
    endtask

    task automatic req(input logic [1:0] op, input logic [31:0] exp_res);
        drive(1'b0, 8'd0, 1'b1, 8'd14, op, exp_res);
    endtask

    task automatic idle();
        drive(1'b0, 8'd0, 1'b0, 8'd0, 2'd0, 32'd0);
    endtask

    function automatic logic [31:0] mkw(input logic [7:0] base, input int unsigned n);
        logic [7:0] b0;
        b0 = base + 8'(4 * n);
        return {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3};
    endfunction

    initial begin
        reset = 1'b1; pixelValid = 1'b0; pixelGray = '0; start = 1'b0;
        iseId = '0; valueA = '0; valueB = '0;
        @(negedge clock);
        @(negedge clock);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        reset = 1'b0;

        // Basic pack and pop, then status.
        pixel(8'h11); pixel(8'h22); pixel(8'h33); pixel(8'h44);
        req(2'd0, 32'h1122_3344);
        req(2'd1, 32'h4000_0000);

        // Pop on empty.
        req(2'd0, 32'h0000_0000);
        req(2'd1, 32'h4000_0000);

        // 36 pixels: eight words fit, ninth overflows.
        for (int p = 0; p < 36; p++) pixel(8'(p));
        req(2'd1, 32'hA000_0008);
        for (int n = 0; n < 8; n++) req(2'd0, mkw(8'h00, n));
        req(2'd1, 32'hC000_0000);
        req(2'd2, 32'h0000_0000);
        req(2'd1, 32'h4000_0000);

        // Foreign iseId must neither answer nor disturb the FIFO.
        pixel(8'hDE); pixel(8'hAD); pixel(8'hBE); pixel(8'hEF);
        drive(1'b0, 8'd0, 1'b1, 8'd47, 2'd0, 32'd0);
        drive(1'b0, 8'd0, 1'b1, 8'd47, 2'd2, 32'd0);
        idle();
        req(2'd1, 32'h0000_0001);
        req(2'd0, 32'hDEAD_BEEF);

        // Pixel on the same edge as clear is dropped.
        pixel(8'h01); pixel(8'h02); pixel(8'h03);
        drive(1'b1, 8'h04, 1'b1, 8'd14, 2'd2, 32'd0);
        req(2'd1, 32'h4000_0000);

        // Word completion coinciding with a pop on empty.
        pixel(8'h01); pixel(8'h02); pixel(8'h03);
        drive(1'b1, 8'h04, 1'b1, 8'd14, 2'd0, 32'd0);
        req(2'd1, 32'h0000_0001);
        req(2'd0, 32'h0102_0304);

        // Reserved op.
        req(2'd3, 32'h0000_0000);
        req(2'd1, 32'h4000_0000);

        // Reset mid-packing and mid-request.
        pixel(8'h55); pixel(8'h66);
        req(2'd1, 32'h4000_0200);
        @(negedge clock);
        pixelValid = 1'b0; start = 1'b1; iseId = 8'd14; valueA = 32'd1;
        @(posedge clock);
        #2 reset = 1'b1;
        start = 1'b0;
        #1;
        check("reset_async_done", {31'd0, done}, 32'd0);
        check("reset_async_result", result, 32'd0);
        @(negedge clock);
        start = 1'b1; valueA = 32'd0;
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        idle();
        req(2'd1, 32'h4000_0000);
        pixel(8'hA1); pixel(8'hA2); pixel(8'hA3); pixel(8'hA4);
        req(2'd0, 32'hA1A2_A3A4);

        // Full FIFO: pop coincides with a completing word.
        for (int p = 0; p < 35; p++) pixel(8'h80 + 8'(p));
        drive(1'b1, 8'h80 + 8'd35, 1'b1, 8'd14, 2'd0, mkw(8'h80, 0));
        req(2'd1, 32'h2000_0008);
        for (int n = 1; n < 9; n++) req(2'd0, mkw(8'h80, n));
        req(2'd1, 32'h4000_0000);

        idle(); idle(); idle();
        if (q.size() > 0) check("scoreboard_drained", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
